// File: rtl/jogao_pkg.sv
// Shared types for the board input path: detector state codes, board geometry,
// and the one-hot to position decoder.
package jogao_pkg;

    localparam int N_BOTOES = 9;
    localparam int W_POS    = 4;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        FILTRA   = 3'd1,
        VALIDA   = 3'd2,
        ENTREGA  = 3'd3,
        INVALIDA = 3'd4,
        SOLTA    = 3'd5
    } estado_t;

    typedef struct packed {
        logic             valida;
        logic [W_POS-1:0] pos;
    } pos_t;

    // valida is set only when exactly one bit is set; pos is then its index
    function automatic pos_t onehot_para_pos(input logic [N_BOTOES-1:0] v);
        pos_t r;
        int   n;
        r.valida = 1'b0;
        r.pos    = '0;
        n        = 0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (v[i]) begin
                n     = n + 1;
                r.pos = W_POS'(i);
            end
        end
        r.valida = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// Two-flop synchroniser, parameterised width, cleared to 0 on reset.
// Latency 2 cycles; no flow control.
module sincronizador #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// Debounces the 9 board buttons, rejects multi-press, delivers one encoded play (DETECTOR_JOGADA_TIMEOUT_EN adds an idle timeout).
// Latency: 2 + DEBOUNCE_CICLOS + 2 cycles from button edge to tem_jogada.
// Backpressure: tem_jogada/jogada held until consome; a new play needs full release first.
module detector_jogada
    import jogao_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    , parameter int TIMEOUT_CICLOS = 500000000
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    input  logic                consome,
    input  logic                zera,
    output logic                tem_jogada,
    output logic [W_POS-1:0]    jogada,
    output logic                jogada_invalida,
    output logic [2:0]          db_estado
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    , output logic              timeout
`endif
);

    localparam int               W_CNT   = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [W_CNT-1:0] CNT_ULT = W_CNT'(DEBOUNCE_CICLOS - 1);
    localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(DEBOUNCE_CICLOS);

    logic [N_BOTOES-1:0] s;
    logic [N_BOTOES-1:0] padrao, padrao_prox;
    estado_t             estado, estado_prox;
    logic [W_CNT-1:0]    cnt, cnt_prox;
    logic [W_POS-1:0]    jogada_prox;
    pos_t                dec;

    sincronizador #(.W(N_BOTOES)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (s)
    );

    assign dec = onehot_para_pos(padrao);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            cnt    <= '0;
            padrao <= '0;
            jogada <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
            padrao <= padrao_prox;
            jogada <= jogada_prox;
        end
    end

    always_comb begin
        estado_prox     = estado;
        cnt_prox        = cnt;
        padrao_prox     = padrao;
        jogada_prox     = jogada;
        tem_jogada      = 1'b0;
        jogada_invalida = 1'b0;
        db_estado       = estado;

        case (estado)
            OCIOSO: begin
                if (habilita && (s != '0)) begin
                    padrao_prox = s;
                    cnt_prox    = '0;
                    estado_prox = FILTRA;
                end
            end
            FILTRA: begin
                if (!habilita || (s != padrao)) begin
                    estado_prox = OCIOSO;
                end else if (cnt == CNT_ULT) begin
                    estado_prox = VALIDA;
                end else if (cnt != CNT_MAX) begin
                    cnt_prox = cnt + 1'b1;
                end
            end
            VALIDA: begin
                cnt_prox = '0;
                if (dec.valida) begin
                    jogada_prox = dec.pos;
                    estado_prox = ENTREGA;
                end else begin
                    estado_prox = INVALIDA;
                end
            end
            ENTREGA: begin
                tem_jogada = 1'b1;
                cnt_prox   = '0;
                if (consome) estado_prox = SOLTA;
            end
            INVALIDA: begin
                jogada_invalida = 1'b1;
                cnt_prox        = '0;
                estado_prox     = SOLTA;
            end
            SOLTA: begin
                // any press restarts the release window, so a held button never re-arms
                if (s != '0) begin
                    cnt_prox = '0;
                end else if (cnt == CNT_ULT) begin
                    estado_prox = OCIOSO;
                end else if (cnt != CNT_MAX) begin
                    cnt_prox = cnt + 1'b1;
                end
            end
            default: begin
                estado_prox = OCIOSO;
                cnt_prox    = '0;
            end
        endcase

        if (zera) begin
            estado_prox = OCIOSO;
            cnt_prox    = '0;
            jogada_prox = '0;
        end
    end

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    localparam int W_TMO = $clog2(TIMEOUT_CICLOS + 1);

    logic [W_TMO-1:0] tmo_cnt;
    logic             tmo_corre;

    assign tmo_corre = habilita && ((estado == OCIOSO) || (estado == FILTRA));
    assign timeout   = tmo_corre && !zera && (tmo_cnt == W_TMO'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (zera || !habilita || ((estado_prox == ENTREGA) && (estado != ENTREGA))) begin
            tmo_cnt <= '0;
        end else if (tmo_corre) begin
            tmo_cnt <= timeout ? '0 : tmo_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada with DEBOUNCE_CICLOS = 4: vector table plus
// hand-written latency and reset sequences; delivered plays go through a scoreboard.
module tb_detector_jogada;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [8:0] botoes;
    logic       habilita;
    logic       consome;
    logic       zera;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic       jogada_invalida;
    logic [2:0] db_estado;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    logic       timeout;
`endif

    detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .consome         (consome),
        .zera            (zera),
        .tem_jogada      (tem_jogada),
        .jogada          (jogada),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
        , .timeout       (timeout)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] b;
        logic       hab;
        logic       cons;
        logic       zr;
        int         ncyc;
        logic       tem;
        logic [3:0] jog;
        logic       inv;
        logic [2:0] est;
        int         pp;     // -1 nothing, 0..8 play expected, 15 invalid pulse expected
    } vec_t;

    typedef struct packed {
        logic       inv;
        logic [3:0] pos;
    } ev_t;

    vec_t tab[$];
    ev_t  sb[$];
    int   nvec = 0;
    int   nmis = 0;
    logic tem_ant = 1'b0;

    function automatic vec_t mk(input logic [8:0] b, input logic hab, input logic cons,
                                input logic zr, input int ncyc, input logic tem,
                                input logic [3:0] jog, input logic inv,
                                input logic [2:0] est, input int pp);
        vec_t v;
        v.b = b; v.hab = hab; v.cons = cons; v.zr = zr; v.ncyc = ncyc;
        v.tem = tem; v.jog = jog; v.inv = inv; v.est = est; v.pp = pp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int pp);
        ev_t e;
        if (pp == 15) e = '{inv: 1'b1, pos: 4'd0};
        else          e = '{inv: 1'b0, pos: 4'(pp)};
        sb.push_back(e);
    endtask

    task automatic check_event(input logic inv, input logic [3:0] pos);
        ev_t e;
        nvec++;
        if (sb.size() == 0) begin
            nmis++;
            $display("FAIL sb_unexpected: got inv=%0d pos=%0d, expected no event", inv, pos);
        end else begin
            e = sb.pop_front();
            if ((e.inv !== inv) || (!inv && (e.pos !== pos))) begin
                nmis++;
                $display("FAIL sb_event: got inv=%0d pos=%0d, expected inv=%0d pos=%0d",
                         inv, pos, e.inv, e.pos);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (tem_jogada && !tem_ant) check_event(1'b0, jogada);
            if (jogada_invalida)        check_event(1'b1, 4'd0);
        end
        tem_ant = tem_jogada;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        string nm;
        botoes = v.b; habilita = v.hab; consome = v.cons; zera = v.zr;
        if (v.pp >= 0) push_ev(v.pp);
        step(v.ncyc);
        nm = $sformatf("v%0d_tem", idx);   chk(nm, 32'(tem_jogada), 32'(v.tem));
        nm = $sformatf("v%0d_jogada", idx); chk(nm, 32'(jogada), 32'(v.jog));
        nm = $sformatf("v%0d_inv", idx);   chk(nm, 32'(jogada_invalida), 32'(v.inv));
        nm = $sformatf("v%0d_estado", idx); chk(nm, 32'(db_estado), 32'(v.est));
    endtask

    initial begin
        //           botoes     hab   cons  zera  n   tem   jog   inv   est  push
        // idle, consome outside ENTREGA ignored
        tab.push_back(mk(9'h000, 1'b1, 1'b1, 1'b0, 3, 1'b0, 4'd0, 1'b0, 3'd0, -1));
        // bounce on bit 2, then stable
        tab.push_back(mk(9'h004, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 3'd0, -1));
        tab.push_back(mk(9'h000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 3'd1, -1));
        tab.push_back(mk(9'h004, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 3'd0, -1));
        tab.push_back(mk(9'h000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 3'd1, -1));
        tab.push_back(mk(9'h004, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 3'd0, -1));
        tab.push_back(mk(9'h000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 3'd1, -1));
        tab.push_back(mk(9'h004, 1'b1, 1'b0, 1'b0, 7, 1'b0, 4'd0, 1'b0, 3'd2,  2));
        tab.push_back(mk(9'h004, 1'b1, 1'b0, 1'b0, 1, 1'b1, 4'd2, 1'b0, 3'd3, -1));
        tab.push_back(mk(9'h004, 1'b1, 1'b1, 1'b0, 1, 1'b0, 4'd2, 1'b0, 3'd5, -1));
        tab.push_back(mk(9'h000, 1'b1, 1'b0, 1'b0, 6, 1'b0, 4'd2, 1'b0, 3'd0, -1));
        // multi-press rejected, then clean press of bit 8
        tab.push_back(mk(9'h101, 1'b1, 1'b0, 1'b0, 7, 1'b0, 4'd2, 1'b0, 3'd2, 15));
        tab.push_back(mk(9'h101, 1'b1, 1'b0, 1'b0, 1, 1'b0, 4'd2, 1'b1, 3'd4, -1));
        tab.push_back(mk(9'h101, 1'b1, 1'b0, 1'b0, 1, 1'b0, 4'd2, 1'b0, 3'd5, -1));
        tab.push_back(mk(9'h000, 1'b1, 1'b0, 1'b0, 6, 1'b0, 4'd2, 1'b0, 3'd0, -1));
        tab.push_back(mk(9'h100, 1'b1, 1'b0, 1'b0, 8, 1'b1, 4'd8, 1'b0, 3'd3,  8));
        tab.push_back(mk(9'h100, 1'b1, 1'b1, 1'b0, 1, 1'b0, 4'd8, 1'b0, 3'd5, -1));
        tab.push_back(mk(9'h000, 1'b1, 1'b0, 1'b0, 6, 1'b0, 4'd8, 1'b0, 3'd0, -1));
        // hold bit 0 across delivery: no repeat until released
        tab.push_back(mk(9'h001, 1'b1, 1'b0, 1'b0, 8, 1'b1, 4'd0, 1'b0, 3'd3,  0));
        tab.push_back(mk(9'h001, 1'b1, 1'b1, 1'b0, 1, 1'b0, 4'd0, 1'b0, 3'd5, -1));
        tab.push_back(mk(9'h001, 1'b1, 1'b0, 1'b0, 50, 1'b0, 4'd0, 1'b0, 3'd5, -1));
        tab.push_back(mk(9'h000, 1'b1, 1'b0, 1'b0, 6, 1'b0, 4'd0, 1'b0, 3'd0, -1));
        tab.push_back(mk(9'h001, 1'b1, 1'b0, 1'b0, 8, 1'b1, 4'd0, 1'b0, 3'd3,  0));
        tab.push_back(mk(9'h001, 1'b1, 1'b1, 1'b0, 1, 1'b0, 4'd0, 1'b0, 3'd5, -1));
        tab.push_back(mk(9'h000, 1'b1, 1'b0, 1'b0, 6, 1'b0, 4'd0, 1'b0, 3'd0, -1));
        // habilita gating, then zera beats consome in ENTREGA
        tab.push_back(mk(9'h020, 1'b0, 1'b0, 1'b0, 12, 1'b0, 4'd0, 1'b0, 3'd0, -1));
        tab.push_back(mk(9'h020, 1'b1, 1'b0, 1'b0, 6, 1'b1, 4'd5, 1'b0, 3'd3,  5));
        tab.push_back(mk(9'h020, 1'b1, 1'b1, 1'b1, 1, 1'b0, 4'd0, 1'b0, 3'd0, -1));
        tab.push_back(mk(9'h000, 1'b0, 1'b0, 1'b0, 4, 1'b0, 4'd0, 1'b0, 3'd0, -1));

        reset = 1'b0; botoes = '0; habilita = 1'b0; consome = 1'b0; zera = 1'b0;
        #1;
        chk("reset_tem", 32'(tem_jogada), 32'd0);
        chk("reset_jogada", 32'(jogada), 32'd0);
        chk("reset_inv", 32'(jogada_invalida), 32'd0);
        chk("reset_estado", 32'(db_estado), 32'd0);
        step(3);
        reset = 1'b1;

        // clean press of bit 4: exact 2 + D + 2 latency
        botoes = 9'h010; habilita = 1'b1;
        push_ev(4);
        step(2 + D + 1);
        chk("lat_before_tem", 32'(tem_jogada), 32'd0);
        chk("lat_before_estado", 32'(db_estado), 32'd2);
        step(1);
        chk("lat_tem", 32'(tem_jogada), 32'd1);
        chk("lat_jogada", 32'(jogada), 32'd4);
        step(10);
        chk("held_tem", 32'(tem_jogada), 32'd1);
        consome = 1'b1;
        step(1);
        consome = 1'b0;
        chk("consumed_tem", 32'(tem_jogada), 32'd0);
        chk("consumed_estado", 32'(db_estado), 32'd5);
        botoes = '0;
        step(6);
        chk("released_estado", 32'(db_estado), 32'd0);

        // reset asserted mid-FILTRA clears everything without a clock edge
        botoes = 9'h080;
        step(4);
        chk("filtra_estado", 32'(db_estado), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_tem", 32'(tem_jogada), 32'd0);
        chk("async_jogada", 32'(jogada), 32'd0);
        chk("async_inv", 32'(jogada_invalida), 32'd0);
        chk("async_estado", 32'(db_estado), 32'd0);
        botoes = '0; habilita = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);

        foreach (tab[i]) apply(tab[i], i);

        step(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
